// File: rtl/mem_arbiter_pkg.sv
// mem_arb_pkg: shared types and constants for the memory arbiter slice.
//   arb_state_t - arbiter FSM encoding (idle / one transaction outstanding)
//   REQ_*       - fixed requester indices into the per-requester vectors
package mem_arb_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE = 1'b0,
    ARB_WAIT = 1'b1
  } arb_state_t;

  localparam int REQ_IFETCH = 0;
  localparam int REQ_DATA   = 1;
  localparam int REQ_LOADER = 2;

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundles the requester-side handshake and the memory-macro
// port of the arbiter.
//   req_valid/req_we/req_addr/req_wdata - per-requester request fields
//   req_ready  - one-hot accept, rsp_valid - one-hot response strobe
//   rsp_rdata  - shared read-data return bus
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata - single-port memory port
//   busy       - a transaction is outstanding
// Modports: slave = the arbiter, master = requesters plus memory.
interface mem_arbiter_if #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
);

  logic [NUM_REQ-1:0]             req_valid;
  logic [NUM_REQ-1:0]             req_we;
  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0][DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]             req_ready;
  logic [NUM_REQ-1:0]             rsp_valid;
  logic [DATA_W-1:0]              rsp_rdata;
  logic                           mem_en;
  logic                           mem_we;
  logic [ADDR_W-1:0]              mem_addr;
  logic [DATA_W-1:0]              mem_wdata;
  logic [DATA_W-1:0]              mem_rdata;
  logic                           busy;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, busy
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, busy
  );

endinterface

// File: rtl/mem_arbiter_rr_picker.sv
// rr_picker: combinational round-robin selector.
//   req     - request vector, N bits
//   last    - index of the previous winner
//   gnt     - one-hot grant (all zero when no request)
//   gnt_idx - binary index of the grant (0 when no request)
// Priority starts at (last+1) mod N: the request vector is rotated so that
// position becomes bit 0, the lowest set bit is found, and the index is
// rotated back.
module rr_picker #(
  parameter int N = 3
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] last,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_idx
);

  localparam int IW = $clog2(N);

  logic [IW-1:0]  start;
  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [IW:0]    sum;
  logic           found;

  // N need not be a power of two, so the wrap from N-1 back to 0 is explicit.
  always_comb begin
    start = (last == IW'(N-1)) ? '0 : last + IW'(1);
    dbl   = {req, req} >> start;
    rot   = dbl[N-1:0];
  end

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    sum     = '0;
    for (int k = 0; k < N; k++) begin
      if (!found && rot[k]) begin
        found = 1'b1;
        sum   = {1'b0, start} + (IW+1)'(k);
        if (sum >= (IW+1)'(N)) begin
          sum = sum - (IW+1)'(N);
        end
        gnt_idx = sum[IW-1:0];
        gnt     = N'(1) << sum[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter in front of a single-port synchronous
// memory shared by ifetch (0), data (1) and loader (2) requesters.
//   clk   - clock, all state on posedge
//   reset - synchronous active-high; forces every output to 0 while high
//   bus   - mem_arbiter_if.slave: request handshake, response return and
//           memory port
// A request is accepted combinationally in idle; the response arrives
// MEM_LATENCY cycles later, after which the arbiter is idle again.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ     = 3,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_LATENCY = 1
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  bus
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MEM_LATENCY + 1);

  localparam logic [0:0] ST_IDLE = ARB_IDLE;
  localparam logic [0:0] ST_WAIT = ARB_WAIT;

  logic [0:0]         state;
  logic [IDX_W-1:0]   last_grant;
  logic [IDX_W-1:0]   owner;
  logic [CNT_W-1:0]   cnt;
  logic               is_write;

  logic [NUM_REQ-1:0] gnt;
  logic [IDX_W-1:0]   gnt_idx;
  logic               any_req;
  logic               accept;
  logic               rsp_now;

  logic [NUM_REQ-1:0] req_ready_d;
  logic [NUM_REQ-1:0] rsp_valid_d;
  logic [DATA_W-1:0]  rsp_rdata_d;
  logic               mem_en_d;
  logic               mem_we_d;
  logic [ADDR_W-1:0]  mem_addr_d;
  logic [DATA_W-1:0]  mem_wdata_d;

  rr_picker #(.N(NUM_REQ)) u_picker (
    .req     (bus.req_valid),
    .last    (last_grant),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign any_req = |bus.req_valid;
  assign accept  = !reset && (state == ST_IDLE) && any_req;
  assign rsp_now = !reset && (state == ST_WAIT) && (cnt == CNT_W'(1));

  // Output muxes. Everything is gated by reset so nothing leaks while it is
  // held. mem_* depend only on requests and state, never on mem_rdata.
  // Write acknowledges return zero data rather than whatever the macro drives.
  always_comb begin
    req_ready_d = '0;
    rsp_valid_d = '0;
    rsp_rdata_d = '0;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    if (accept) begin
      req_ready_d = gnt;
      mem_en_d    = 1'b1;
      mem_we_d    = bus.req_we[gnt_idx];
      mem_addr_d  = bus.req_addr[gnt_idx];
      mem_wdata_d = bus.req_wdata[gnt_idx];
    end
    if (rsp_now) begin
      rsp_valid_d = NUM_REQ'(1) << owner;
      rsp_rdata_d = is_write ? '0 : bus.mem_rdata;
    end
  end

  assign bus.req_ready = req_ready_d;
  assign bus.rsp_valid = rsp_valid_d;
  assign bus.rsp_rdata = rsp_rdata_d;
  assign bus.mem_en    = mem_en_d;
  assign bus.mem_we    = mem_we_d;
  assign bus.mem_addr  = mem_addr_d;
  assign bus.mem_wdata = mem_wdata_d;
  assign bus.busy      = !reset && (state == ST_WAIT);

  // FSM, latency counter and ownership. last_grant resets to NUM_REQ-1 so
  // requester 0 wins the first tie; it only moves when a grant is made.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      last_grant <= IDX_W'(NUM_REQ - 1);
      owner      <= '0;
      cnt        <= '0;
      is_write   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            owner      <= gnt_idx;
            last_grant <= gnt_idx;
            is_write   <= bus.req_we[gnt_idx];
            cnt        <= CNT_W'(MEM_LATENCY);
            state      <= ST_WAIT;
          end
        end
        default: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state <= ST_IDLE;
          end
        end
      endcase
    end
  end

  // Requesters must hold valid until accepted; grants and responses are
  // always at most one-hot.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_hold
    a_hold_valid: assert property (@(posedge clk) disable iff (reset)
      (bus.req_valid[i] && !req_ready_d[i]) |=> bus.req_valid[i]);
  end

  a_ready_onehot: assert property (@(posedge clk) disable iff (reset)
    $onehot0(req_ready_d));
  a_rsp_onehot: assert property (@(posedge clk) disable iff (reset)
    $onehot0(rsp_valid_d));
  a_no_ready_in_wait: assert property (@(posedge clk) disable iff (reset)
    (state == ST_WAIT) |-> (req_ready_d == '0));

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter. Two instances share the
// clock: dut1 with MEM_LATENCY=1 (backed by a read/write memory model) and
// dut3 with MEM_LATENCY=3 (backed by a read-only 3-stage pipeline).
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  logic clk = 1'b0;
  logic rst1;
  logic rst3;
  int   asserts_evaluated = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  mem_arbiter_if #(.NUM_REQ(3), .ADDR_W(32), .DATA_W(32)) if1 ();
  mem_arbiter_if #(.NUM_REQ(3), .ADDR_W(32), .DATA_W(32)) if3 ();

  mem_arbiter #(.NUM_REQ(3), .ADDR_W(32), .DATA_W(32), .MEM_LATENCY(1)) dut1 (
    .clk   (clk),
    .reset (rst1),
    .bus   (if1.slave)
  );

  mem_arbiter #(.NUM_REQ(3), .ADDR_W(32), .DATA_W(32), .MEM_LATENCY(3)) dut3 (
    .clk   (clk),
    .reset (rst3),
    .bus   (if3.slave)
  );

  // Contents of memory locations never written by the bench.
  function automatic logic [31:0] initWord(input logic [7:0] a);
    return (a == 8'h10) ? 32'hDEADBEEF : {24'hA5A5C3, a};
  endfunction

  // Latency-1 memory: one registered read port, writes tracked per word.
  logic [31:0]  mem1 [0:255];
  logic [255:0] written1;
  logic [31:0]  rd1;

  always @(posedge clk) begin
    if (rst1) begin
      written1 <= '0;
    end else if (if1.mem_en) begin
      if (if1.mem_we) begin
        mem1[if1.mem_addr[7:0]]     <= if1.mem_wdata;
        written1[if1.mem_addr[7:0]] <= 1'b1;
      end else begin
        rd1 <= written1[if1.mem_addr[7:0]] ? mem1[if1.mem_addr[7:0]]
                                           : initWord(if1.mem_addr[7:0]);
      end
    end
  end
  assign if1.mem_rdata = rd1;

  // Latency-3 memory: read data appears three cycles after mem_en.
  logic [31:0] s1, s2, s3;
  always @(posedge clk) begin
    s1 <= if3.mem_en ? initWord(if3.mem_addr[7:0]) : 32'h0;
    s2 <= s1;
    s3 <= s2;
  end
  assign if3.mem_rdata = s3;

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input bit on3, input logic [1:0] idx,
                               input logic v, input logic w,
                               input logic [31:0] a, input logic [31:0] d);
    if (on3) begin
      if3.req_valid[idx] = v;
      if3.req_we[idx]    = w;
      if3.req_addr[idx]  = a;
      if3.req_wdata[idx] = d;
    end else begin
      if1.req_valid[idx] = v;
      if1.req_we[idx]    = w;
      if1.req_addr[idx]  = a;
      if1.req_wdata[idx] = d;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs,
                             input logic [63:0] exp);
    asserts_evaluated++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [1:0] g;
    rst1 = 1'b1;
    rst3 = 1'b1;
    if1.req_valid = '0; if1.req_we = '0; if1.req_addr = '0; if1.req_wdata = '0;
    if3.req_valid = '0; if3.req_we = '0; if3.req_addr = '0; if3.req_wdata = '0;
    nextCycle();
    nextCycle();

    // Outputs masked while reset is high, even with every request raised.
    if1.req_valid = 3'b111;
    if3.req_valid = 3'b111;
    #1;
    checkOutput("rst_ready1", 64'(if1.req_ready), 64'(0));
    checkOutput("rst_mem_en1", 64'(if1.mem_en), 64'(0));
    checkOutput("rst_busy1", 64'(if1.busy), 64'(0));
    checkOutput("rst_ready3", 64'(if3.req_ready), 64'(0));
    checkOutput("rst_mem_en3", 64'(if3.mem_en), 64'(0));
    if1.req_valid = '0;
    if3.req_valid = '0;
    nextCycle();
    rst1 = 1'b0;
    rst3 = 1'b0;

    // Single read, latency 1.
    nextCycle();
    applyStimulus(1'b0, 2'(REQ_IFETCH), 1'b1, 1'b0, 32'h10, 32'h0);
    #1;
    checkOutput("t1_ready", 64'(if1.req_ready), 64'(3'b001));
    checkOutput("t1_mem_en", 64'(if1.mem_en), 64'(1));
    checkOutput("t1_mem_we", 64'(if1.mem_we), 64'(0));
    checkOutput("t1_mem_addr", 64'(if1.mem_addr), 64'(32'h10));
    checkOutput("t1_busy_acc", 64'(if1.busy), 64'(0));
    nextCycle();
    applyStimulus(1'b0, 2'(REQ_IFETCH), 1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    checkOutput("t1_rsp_valid", 64'(if1.rsp_valid), 64'(3'b001));
    checkOutput("t1_rsp_rdata", 64'(if1.rsp_rdata), 64'(32'hDEADBEEF));
    checkOutput("t1_busy_wait", 64'(if1.busy), 64'(1));
    checkOutput("t1_mem_en_wait", 64'(if1.mem_en), 64'(0));
    nextCycle();
    #1;
    checkOutput("t1_busy_done", 64'(if1.busy), 64'(0));
    checkOutput("t1_rsp_done", 64'(if1.rsp_valid), 64'(0));

    // Simultaneous requests held continuously from reset release.
    nextCycle();
    rst1 = 1'b1;
    nextCycle();
    rst1 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 2'(i), 1'b1, 1'b0, 32'h20 + 32'(4 * i), 32'h0);
    end
    #1;
    for (int k = 0; k < 6; k++) begin
      g = 2'(k % 3);
      if (k > 0) begin
        nextCycle();
        #1;
      end
      checkOutput($sformatf("t2_ready_%0d", k), 64'(if1.req_ready), 64'(3'b001 << g));
      checkOutput($sformatf("t2_addr_%0d", k), 64'(if1.mem_addr), 64'(32'h20 + 32'(4 * g)));
      nextCycle();
      #1;
      checkOutput($sformatf("t2_noready_%0d", k), 64'(if1.req_ready), 64'(0));
      checkOutput($sformatf("t2_rsp_%0d", k), 64'(if1.rsp_valid), 64'(3'b001 << g));
      checkOutput($sformatf("t2_rdata_%0d", k), 64'(if1.rsp_rdata),
                  64'(initWord(8'h20 + 8'(4 * g))));
    end
    nextCycle();
    rst1 = 1'b1;
    #1;
    checkOutput("t2_rst_mask", 64'(if1.req_ready), 64'(0));
    nextCycle();
    if1.req_valid = '0;
    rst1 = 1'b0;
    #1;
    checkOutput("t2_idle_after", 64'({if1.req_ready, if1.mem_en, if1.busy}), 64'(0));

    // Requester 1 writes then reads back.
    nextCycle();
    applyStimulus(1'b0, 2'(REQ_DATA), 1'b1, 1'b1, 32'h40, 32'h12345678);
    #1;
    checkOutput("t3_wr_ready", 64'(if1.req_ready), 64'(3'b010));
    checkOutput("t3_wr_mem_we", 64'(if1.mem_we), 64'(1));
    checkOutput("t3_wr_wdata", 64'(if1.mem_wdata), 64'(32'h12345678));
    checkOutput("t3_wr_addr", 64'(if1.mem_addr), 64'(32'h40));
    nextCycle();
    applyStimulus(1'b0, 2'(REQ_DATA), 1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    checkOutput("t3_wr_ack", 64'(if1.rsp_valid), 64'(3'b010));
    checkOutput("t3_wr_rdata", 64'(if1.rsp_rdata), 64'(0));
    checkOutput("t3_wr_we_wait", 64'(if1.mem_we), 64'(0));
    nextCycle();
    applyStimulus(1'b0, 2'(REQ_DATA), 1'b1, 1'b0, 32'h40, 32'h0);
    #1;
    checkOutput("t3_rd_ready", 64'(if1.req_ready), 64'(3'b010));
    checkOutput("t3_rd_mem_we", 64'(if1.mem_we), 64'(0));
    nextCycle();
    applyStimulus(1'b0, 2'(REQ_DATA), 1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    checkOutput("t3_rd_rsp", 64'(if1.rsp_valid), 64'(3'b010));
    checkOutput("t3_rd_rdata", 64'(if1.rsp_rdata), 64'(32'h12345678));

    // Ten idle cycles, then a tie between 0 and 2 that shows last_grant=1 held.
    for (int k = 0; k < 10; k++) begin
      nextCycle();
      #1;
      checkOutput($sformatf("t6_idle_%0d", k),
                  {if1.req_ready, if1.rsp_valid, if1.mem_en, if1.mem_we, if1.busy,
                   if1.mem_addr[23:0], if1.rsp_rdata[25:0]}, 64'(0));
    end
    nextCycle();
    applyStimulus(1'b0, 2'(REQ_IFETCH), 1'b1, 1'b0, 32'h30, 32'h0);
    applyStimulus(1'b0, 2'(REQ_LOADER), 1'b1, 1'b0, 32'h34, 32'h0);
    #1;
    checkOutput("t6_tie_ready", 64'(if1.req_ready), 64'(3'b100));
    checkOutput("t6_tie_addr", 64'(if1.mem_addr), 64'(32'h34));
    nextCycle();
    applyStimulus(1'b0, 2'(REQ_LOADER), 1'b1, 1'b0, 32'h2C, 32'h0);
    #1;
    checkOutput("t6_rsp2", 64'(if1.rsp_valid), 64'(3'b100));
    checkOutput("t6_rdata2", 64'(if1.rsp_rdata), 64'(initWord(8'h34)));
    checkOutput("t6_noready_rsp", 64'(if1.req_ready), 64'(0));
    nextCycle();
    #1;
    checkOutput("t6_b2b_ready", 64'(if1.req_ready), 64'(3'b001));
    checkOutput("t6_b2b_addr", 64'(if1.mem_addr), 64'(32'h30));
    nextCycle();
    applyStimulus(1'b0, 2'(REQ_IFETCH), 1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    checkOutput("t6_rsp0", 64'(if1.rsp_valid), 64'(3'b001));
    checkOutput("t6_rdata0", 64'(if1.rsp_rdata), 64'(initWord(8'h30)));
    nextCycle();
    #1;
    checkOutput("t6_reassert_ready", 64'(if1.req_ready), 64'(3'b100));
    checkOutput("t6_reassert_addr", 64'(if1.mem_addr), 64'(32'h2C));
    nextCycle();
    applyStimulus(1'b0, 2'(REQ_LOADER), 1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    checkOutput("t6_reassert_rdata", 64'(if1.rsp_rdata), 64'(initWord(8'h2C)));

    // Latency 3: single read with requester 1 waiting alongside.
    nextCycle();
    applyStimulus(1'b1, 2'(REQ_IFETCH), 1'b1, 1'b0, 32'h10, 32'h0);
    applyStimulus(1'b1, 2'(REQ_DATA), 1'b1, 1'b0, 32'h14, 32'h0);
    #1;
    checkOutput("t4_ready", 64'(if3.req_ready), 64'(3'b001));
    checkOutput("t4_mem_en", 64'(if3.mem_en), 64'(1));
    nextCycle();
    applyStimulus(1'b1, 2'(REQ_IFETCH), 1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    checkOutput("t4_wait1", 64'({if3.req_ready, if3.rsp_valid}), 64'(0));
    nextCycle();
    #1;
    checkOutput("t4_wait2", 64'({if3.req_ready, if3.rsp_valid}), 64'(0));
    nextCycle();
    #1;
    checkOutput("t4_wait3_ready", 64'(if3.req_ready), 64'(0));
    checkOutput("t4_rsp", 64'(if3.rsp_valid), 64'(3'b001));
    checkOutput("t4_rdata", 64'(if3.rsp_rdata), 64'(32'hDEADBEEF));
    checkOutput("t4_busy", 64'(if3.busy), 64'(1));
    nextCycle();
    #1;
    checkOutput("t4_next_ready", 64'(if3.req_ready), 64'(3'b010));
    checkOutput("t4_next_addr", 64'(if3.mem_addr), 64'(32'h14));
    nextCycle();
    applyStimulus(1'b1, 2'(REQ_DATA), 1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    nextCycle();
    #1;
    nextCycle();
    #1;
    checkOutput("t4_rsp1", 64'(if3.rsp_valid), 64'(3'b010));
    checkOutput("t4_rdata1", 64'(if3.rsp_rdata), 64'(initWord(8'h14)));

    // Reset one cycle into a latency-3 read; the transaction is abandoned.
    nextCycle();
    applyStimulus(1'b1, 2'(REQ_IFETCH), 1'b1, 1'b0, 32'h18, 32'h0);
    applyStimulus(1'b1, 2'(REQ_LOADER), 1'b1, 1'b0, 32'h1C, 32'h0);
    #1;
    checkOutput("t5_ready", 64'(if3.req_ready), 64'(3'b100));
    nextCycle();
    rst3 = 1'b1;
    applyStimulus(1'b1, 2'(REQ_LOADER), 1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    checkOutput("t5_rst_outs", 64'({if3.req_ready, if3.rsp_valid, if3.busy}), 64'(0));
    nextCycle();
    rst3 = 1'b0;
    applyStimulus(1'b1, 2'(REQ_LOADER), 1'b1, 1'b0, 32'h1C, 32'h0);
    #1;
    checkOutput("t5_tie_ready", 64'(if3.req_ready), 64'(3'b001));
    checkOutput("t5_tie_addr", 64'(if3.mem_addr), 64'(32'h18));
    nextCycle();
    applyStimulus(1'b1, 2'(REQ_IFETCH), 1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    checkOutput("t5_no_rsp_a", 64'(if3.rsp_valid), 64'(0));
    nextCycle();
    #1;
    checkOutput("t5_no_rsp_b", 64'(if3.rsp_valid), 64'(0));
    nextCycle();
    #1;
    checkOutput("t5_rsp0", 64'(if3.rsp_valid), 64'(3'b001));
    checkOutput("t5_rdata0", 64'(if3.rsp_rdata), 64'(initWord(8'h18)));
    nextCycle();
    #1;
    checkOutput("t5_ready2", 64'(if3.req_ready), 64'(3'b100));
    nextCycle();
    applyStimulus(1'b1, 2'(REQ_LOADER), 1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    repeat (4) nextCycle();

    $display("End of test - %0d assertions evaluated, %0d failures",
             asserts_evaluated, failures);
    $finish;
  end

endmodule
